sccb_cfg_seq: RTL and testbench

SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

---
 rtl/sccb_cfg_seq.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_sccb_cfg_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: walks a register table and writes each entry to an SCCB
// (I2C-like, write-only) camera sensor. Entries flagged is_delay idle the
// bus for value*DELAY_CYC clocks instead. A NACKed frame is retried up to
// MAX_RETRY times before the sequence stops in an error state.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse, (re)runs the table from entry 0 when not busy
//   lut_addr      table index presented to the external table
//   lut_data      {is_delay, reg_addr, value}, valid one clk after lut_addr changes
//   scl           SCCB clock (push-pull)
//   sda_oe        1 = pull SDA low, 0 = release
//   sda_i         synchronised SDA line
//   busy          sequence running
//   done          whole table written (level)
//   error         retries exhausted (level)
//   err_index     table index of the failing entry
module sccb_cfg_seq #(
  parameter int unsigned SCL_DIV    = 250,
  parameter logic [7:0]  DEV_ADDR   = 8'h60,
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned LUT_DEPTH  = 178,
  parameter int unsigned AW         = 8,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DELAY_CYC  = 100000,
  parameter int unsigned AUTO_START = 1,
  localparam int unsigned W         = 8*ADDR_BYTES+9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] lut_addr,
  input  logic [W-1:0]  lut_data,
  output logic          scl,
  output logic          sda_oe,
  input  logic          sda_i,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_index
);

  localparam int unsigned PW     = 8*ADDR_BYTES+8;
  localparam int unsigned TW     = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;
  localparam int unsigned RW     = ($clog2(MAX_RETRY+1) > 0) ? $clog2(MAX_RETRY+1) : 1;
  localparam int unsigned DW     = ($clog2(255*DELAY_CYC+1) > 0) ? $clog2(255*DELAY_CYC+1) : 1;
  localparam logic [1:0]  LAST_B = 2'(ADDR_BYTES+1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DELAY, S_DONE, S_ERR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick;
  logic          w_tick;
  logic [1:0]    r_q, w_q_nxt;
  logic [2:0]    r_bitn, w_bitn_nxt;
  logic [1:0]    r_byte, w_byte_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [PW-1:0] r_payload, w_payload_nxt;
  logic          r_fetch2, w_fetch2_nxt;
  logic          r_nack, w_nack_nxt;
  logic          r_fail, w_fail_nxt;
  logic [RW-1:0] r_retry, w_retry_nxt;
  logic [DW-1:0] r_dly, w_dly_nxt;
  logic          r_auto;
  logic          r_scl, w_scl_nxt;
  logic          r_sda_oe, w_sda_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic [AW-1:0] r_lut_addr, w_lut_addr_nxt;
  logic [AW-1:0] r_err_index, w_err_index_nxt;
  logic          w_trig;
  logic          w_adv;

  // Quarter-period tick; held cleared in IDLE so the first quarter is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  assign w_tick = (r_state != S_IDLE) && (r_tick == TW'(SCL_DIV-1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_bitn      <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
      r_payload   <= '0;
      r_fetch2    <= 1'b0;
      r_nack      <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_auto      <= (AUTO_START != 0);
      r_scl       <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_lut_addr  <= '0;
      r_err_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_q         <= w_q_nxt;
      r_bitn      <= w_bitn_nxt;
      r_byte      <= w_byte_nxt;
      r_shift     <= w_shift_nxt;
      r_payload   <= w_payload_nxt;
      r_fetch2    <= w_fetch2_nxt;
      r_nack      <= w_nack_nxt;
      r_fail      <= w_fail_nxt;
      r_retry     <= w_retry_nxt;
      r_dly       <= w_dly_nxt;
      r_auto      <= 1'b0;
      r_scl       <= w_scl_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_lut_addr  <= w_lut_addr_nxt;
      r_err_index <= w_err_index_nxt;
    end
  end

  // Next-state, datapath and bus-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_q_nxt         = r_q;
    w_bitn_nxt      = r_bitn;
    w_byte_nxt      = r_byte;
    w_shift_nxt     = r_shift;
    w_payload_nxt   = r_payload;
    w_fetch2_nxt    = r_fetch2;
    w_nack_nxt      = r_nack;
    w_fail_nxt      = r_fail;
    w_retry_nxt     = r_retry;
    w_dly_nxt       = r_dly;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_lut_addr_nxt  = r_lut_addr;
    w_err_index_nxt = r_err_index;
    w_scl_nxt       = 1'b1;
    w_sda_oe_nxt    = 1'b0;
    w_adv           = 1'b0;
    w_trig          = r_auto ||
                      (start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR));

    case (r_state)
      S_FETCH: begin
        // First clk lets the table respond to the new address; second captures it.
        if (!r_fetch2) begin
          w_fetch2_nxt = 1'b1;
        end else begin
          w_fetch2_nxt  = 1'b0;
          w_payload_nxt = lut_data[PW-1:0];
          w_fail_nxt    = 1'b0;
          w_q_nxt       = 2'd0;
          if (lut_data[W-1]) begin
            w_dly_nxt   = DW'(lut_data[7:0]) * DW'(DELAY_CYC);
            w_state_nxt = S_DELAY;
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_q == 2'd0) begin
            w_q_nxt = 2'd1;
          end else begin
            w_q_nxt     = 2'd0;
            w_bitn_nxt  = 3'd7;
            w_byte_nxt  = 2'd0;
            w_shift_nxt = DEV_ADDR;
            w_state_nxt = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (r_bitn == 3'd0) begin
              w_state_nxt = S_ACK;
            end else begin
              w_bitn_nxt  = r_bitn - 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
      end
      S_ACK: begin
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd2) begin
            w_nack_nxt = sda_i;
          end
          if (r_q == 2'd3) begin
            if (r_nack) begin
              w_fail_nxt  = 1'b1;
              w_state_nxt = S_STOP;
            end else if (r_byte == LAST_B) begin
              w_state_nxt = S_STOP;
            end else begin
              // Payload shifts out reg_addr MSB byte first, then value.
              w_byte_nxt    = r_byte + 2'd1;
              w_shift_nxt   = r_payload[PW-1 -: 8];
              w_payload_nxt = r_payload << 8;
              w_bitn_nxt    = 3'd7;
              w_state_nxt   = S_BYTE;
            end
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_q == 2'd2) begin
            w_q_nxt     = 2'd0;
            w_state_nxt = S_GAP;
          end else begin
            w_q_nxt = r_q + 2'd1;
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (!r_fail) begin
              w_adv = 1'b1;
            end else if (r_retry < RW'(MAX_RETRY)) begin
              w_retry_nxt  = r_retry + RW'(1);
              w_fetch2_nxt = 1'b0;
              w_state_nxt  = S_FETCH;
            end else begin
              w_err_index_nxt = r_lut_addr;
              w_error_nxt     = 1'b1;
              w_busy_nxt      = 1'b0;
              w_state_nxt     = S_ERR;
            end
          end
        end
      end
      S_DELAY: begin
        if (r_dly == '0) begin
          w_adv = 1'b1;
        end else begin
          w_dly_nxt = r_dly - DW'(1);
        end
      end
      default: ;
    endcase

    // Successful write or finished delay: step to the next entry.
    if (w_adv) begin
      w_retry_nxt = '0;
      if (r_lut_addr == AW'(LUT_DEPTH-1)) begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_DONE;
      end else begin
        w_lut_addr_nxt = r_lut_addr + AW'(1);
        w_fetch2_nxt   = 1'b0;
        w_state_nxt    = S_FETCH;
      end
    end

    if (w_trig) begin
      w_lut_addr_nxt = '0;
      w_done_nxt     = 1'b0;
      w_error_nxt    = 1'b0;
      w_busy_nxt     = 1'b1;
      w_retry_nxt    = '0;
      w_fetch2_nxt   = 1'b0;
      w_state_nxt    = S_FETCH;
    end

    // Bus levels follow the next state so they line up with it when registered.
    case (w_state_nxt)
      S_START: w_sda_oe_nxt = (w_q_nxt == 2'd1);
      S_BYTE: begin
        w_scl_nxt    = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
        w_sda_oe_nxt = ~w_shift_nxt[7];
      end
      S_ACK:   w_scl_nxt = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
      S_STOP: begin
        w_scl_nxt    = (w_q_nxt != 2'd0);
        w_sda_oe_nxt = (w_q_nxt != 2'd2);
      end
      default: ;
    endcase
  end

  assign lut_addr  = r_lut_addr;
  assign scl       = r_scl;
  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_index = r_err_index;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Bench for sccb_cfg_seq: three instances (1-byte addr with auto start,
// 2-byte addr, 4-entry retry/error), one shared SCCB slave model that decodes
// frames and answers ACK/NACK, and a scoreboard queue of expected bytes and
// per-frame SCL pulse counts. Instances are exercised one at a time.
module tb_sccb_cfg_seq;

  typedef struct {
    int id;
    int kind;   // 0 = byte, 1 = SCL pulses in frame
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] start_r, scl_w, oe_w, sda_w, busy_w, done_w, err_w;
  logic [2:0] slv_low;
  logic [7:0] addr_w [3];
  logic [7:0] eidx_w [3];
  logic [24:0] tab [3][4];
  logic [16:0] ld0, ld2;
  logic [24:0] ld1;

  assign sda_w = ~(oe_w | slv_low);

  // External table: one clk read latency.
  always @(posedge clk) begin
    ld0 <= tab[0][addr_w[0][1:0]][16:0];
    ld1 <= tab[1][addr_w[1][1:0]];
    ld2 <= tab[2][addr_w[2][1:0]][16:0];
  end

  sccb_cfg_seq #(.SCL_DIV(2), .DEV_ADDR(8'h60), .ADDR_BYTES(1), .LUT_DEPTH(3), .AW(8),
                 .MAX_RETRY(3), .DELAY_CYC(100), .AUTO_START(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .lut_addr(addr_w[0]), .lut_data(ld0),
    .scl(scl_w[0]), .sda_oe(oe_w[0]), .sda_i(sda_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .error(err_w[0]), .err_index(eidx_w[0]));

  sccb_cfg_seq #(.SCL_DIV(2), .DEV_ADDR(8'h60), .ADDR_BYTES(2), .LUT_DEPTH(1), .AW(8),
                 .MAX_RETRY(3), .DELAY_CYC(100), .AUTO_START(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .lut_addr(addr_w[1]), .lut_data(ld1),
    .scl(scl_w[1]), .sda_oe(oe_w[1]), .sda_i(sda_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .error(err_w[1]), .err_index(eidx_w[1]));

  sccb_cfg_seq #(.SCL_DIV(2), .DEV_ADDR(8'h60), .ADDR_BYTES(1), .LUT_DEPTH(4), .AW(8),
                 .MAX_RETRY(3), .DELAY_CYC(100), .AUTO_START(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .lut_addr(addr_w[2]), .lut_data(ld2),
    .scl(scl_w[2]), .sda_oe(oe_w[2]), .sda_i(sda_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .error(err_w[2]), .err_index(eidx_w[2]));

  ev_t exp_q[$];
  int  nack_q[$];
  int  total = 0;
  int  bad = 0;

  // Slave model state.
  int   in_frame [3];
  int   bitcnt [3];
  int   pulses [3];
  int   byteidx [3];
  int   nack_at [3];
  int   frames [3];
  int   acking [3];
  logic [7:0] shreg [3];
  logic p_scl [3];
  logic p_l [3];
  logic s_now, l_now;
  int   cyc = 0;
  int   last_edge = 0;
  int   have_last = 0;
  int   max_gap = 0;
  int   max_addr2 = 0;
  bit   meas_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_ev(input int k, input int kind, input int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected dut%0d kind=%0d got=%0h want=nothing", k, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.id != k || e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL sb_%s dut%0d got=%0h want dut%0d kind=%0d val=%0h",
                 (kind == 0) ? "byte" : "pulses", k, val, e.id, e.kind, e.val);
      end
    end
  endtask

  // Monitor / slave: samples the buses on the falling clk edge.
  always @(negedge clk) begin
    if (addr_w[2] > 8'(max_addr2)) max_addr2 = int'(addr_w[2]);
    for (int k = 0; k < 3; k++) begin
      s_now = scl_w[k];
      l_now = ~(oe_w[k] | slv_low[k]);
      if (!rst_n) begin
        in_frame[k] = 0;
        acking[k]   = 0;
        slv_low[k]  = 1'b0;
        s_now       = 1'b1;
        l_now       = 1'b1;
      end else begin
        if (k == 0) begin
          if (!meas_en) begin
            have_last = 0;
            max_gap   = 0;
          end else if (s_now != p_scl[k]) begin
            if (have_last != 0 && cyc - last_edge > max_gap) max_gap = cyc - last_edge;
            last_edge = cyc;
            have_last = 1;
          end
        end
        if (p_scl[k] && s_now && p_l[k] && !l_now) begin
          in_frame[k] = 1;
          bitcnt[k]   = 0;
          pulses[k]   = 0;
          byteidx[k]  = 0;
          acking[k]   = 0;
          frames[k]++;
          nack_at[k]  = (nack_q.size() > 0) ? nack_q.pop_front() : -1;
        end else if (in_frame[k] != 0 && p_scl[k] && s_now && !p_l[k] && l_now) begin
          in_frame[k] = 0;
          check_ev(k, 1, pulses[k] - 1);   // last rise belongs to STOP
        end else if (in_frame[k] != 0 && !p_scl[k] && s_now) begin
          pulses[k]++;
          if (bitcnt[k] < 8) begin
            shreg[k] = {shreg[k][6:0], l_now};
            bitcnt[k]++;
          end
        end else if (in_frame[k] != 0 && p_scl[k] && !s_now) begin
          if (acking[k] != 0) begin
            slv_low[k] = 1'b0;
            acking[k]  = 0;
            bitcnt[k]  = 0;
            byteidx[k]++;
          end else if (bitcnt[k] == 8) begin
            check_ev(k, 0, int'(shreg[k]));
            acking[k]  = 1;
            slv_low[k] = (byteidx[k] != nack_at[k]);
          end
        end
      end
      p_scl[k] = s_now;
      p_l[k]   = l_now;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int k, input int nb, input logic [31:0] bytes,
                            input int np, input int nack);
    ev_t e;
    for (int i = 0; i < nb; i++) begin
      e.id = k; e.kind = 0; e.val = int'(bytes[8*(nb-1-i) +: 8]);
      exp_q.push_back(e);
    end
    e.id = k; e.kind = 1; e.val = np;
    exp_q.push_back(e);
    nack_q.push_back(nack);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk) start_r[k] = 1'b1;
    @(negedge clk) start_r[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int limit);
    int n;
    n = 0;
    while (!(done_w[k] || err_w[k]) && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL timeout_dut%0d waited=%0d limit=%0d", k, n, limit);
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    rst_n   = 1'b0;
    start_r = '0;
    slv_low = '0;
    for (int k = 0; k < 3; k++) begin
      in_frame[k] = 0; bitcnt[k] = 0; pulses[k] = 0; byteidx[k] = 0;
      nack_at[k] = -1; frames[k] = 0; acking[k] = 0; shreg[k] = '0;
      p_scl[k] = 1'b1; p_l[k] = 1'b1;
      for (int i = 0; i < 4; i++) tab[k][i] = '0;
    end
    tab[0][0] = 25'({1'b0, 8'hFF, 8'h01});
    tab[0][1] = 25'({1'b0, 8'h12, 8'h80});
    tab[0][2] = 25'({1'b0, 8'h11, 8'h01});
    tab[1][0] = {1'b0, 16'h3008, 8'h82};
    tab[2][0] = 25'({1'b0, 8'hAA, 8'h01});
    tab[2][1] = 25'({1'b0, 8'hBB, 8'h02});
    tab[2][2] = 25'({1'b0, 8'hCC, 8'h03});
    tab[2][3] = 25'({1'b0, 8'hDD, 8'h04});

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", int'(scl_w[0]), 1);
    chk("rst_sda_oe", int'(oe_w[0]), 0);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_done", int'(done_w[0]), 0);
    chk("rst_error", int'(err_w[0]), 0);
    chk("rst_lut_addr", int'(addr_w[0]), 0);
    chk("rst_err_index", int'(eidx_w[0]), 0);

    // Auto-start after reset: three 1-byte-address frames; a start while busy is ignored.
    push_frame(0, 3, 32'h60FF01, 27, -1);
    push_frame(0, 3, 32'h601280, 27, -1);
    push_frame(0, 3, 32'h601101, 27, -1);
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("t1_busy_mid", int'(busy_w[0]), 1);
    pulse_start(0);
    wait_done(0, 4000);
    chk("t1_done", int'(done_w[0]), 1);
    chk("t1_error", int'(err_w[0]), 0);
    chk("t1_busy_end", int'(busy_w[0]), 0);
    chk("t1_lut_addr", int'(addr_w[0]), 2);
    quiet(200);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_bus_idle", int'({scl_w[0], oe_w[0]}), 2);

    // Single NACK on the value byte of entry 1: entry 1 resent once.
    push_frame(0, 3, 32'h60FF01, 27, -1);
    push_frame(0, 3, 32'h601280, 27, 2);
    push_frame(0, 3, 32'h601280, 27, -1);
    push_frame(0, 3, 32'h601101, 27, -1);
    pulse_start(0);
    wait_done(0, 5000);
    chk("t2_done", int'(done_w[0]), 1);
    chk("t2_error", int'(err_w[0]), 0);
    quiet(50);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Entry 1 is a delay of 5 units (500 clks): no SCL edge across it.
    tab[0][1] = 25'({1'b1, 8'h00, 8'h05});
    push_frame(0, 3, 32'h60FF01, 27, -1);
    push_frame(0, 3, 32'h601101, 27, -1);
    meas_en = 1'b1;
    pulse_start(0);
    wait_done(0, 4000);
    chk("t3_done", int'(done_w[0]), 1);
    total++;
    if (max_gap < 500 || max_gap > 540) begin
      bad++;
      $display("FAIL t3_delay_gap got=%0d want=500..540", max_gap);
    end
    meas_en = 1'b0;
    quiet(50);
    chk("t3_sb_empty", exp_q.size(), 0);
    tab[0][1] = 25'({1'b0, 8'h12, 8'h80});

    // Reset in the middle of entry 1's first byte, then a full rerun.
    base = frames[0];
    push_frame(0, 3, 32'h60FF01, 27, -1);
    nack_q.push_back(-1);
    pulse_start(0);
    n = 0;
    while (!(frames[0] >= base + 2 && pulses[0] >= 3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL t4_reach_entry1 waited=%0d limit=2000", n);
    end
    chk("t4_addr_before", int'(addr_w[0]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_scl", int'(scl_w[0]), 1);
    chk("t4_rst_sda_oe", int'(oe_w[0]), 0);
    chk("t4_rst_busy", int'(busy_w[0]), 0);
    chk("t4_rst_lut_addr", int'(addr_w[0]), 0);
    push_frame(0, 3, 32'h60FF01, 27, -1);
    push_frame(0, 3, 32'h601280, 27, -1);
    push_frame(0, 3, 32'h601101, 27, -1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(0, 4000);
    chk("t4_done", int'(done_w[0]), 1);
    chk("t4_lut_addr", int'(addr_w[0]), 2);
    quiet(50);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Two-byte register address.
    push_frame(1, 4, 32'h60300882, 36, -1);
    pulse_start(1);
    wait_done(1, 3000);
    chk("t5_done", int'(done_w[1]), 1);
    chk("t5_error", int'(err_w[1]), 0);
    chk("t5_busy", int'(busy_w[1]), 0);
    quiet(50);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Persistent NACK on the device address of entry 2: 4 attempts then error.
    push_frame(2, 3, 32'h60AA01, 27, -1);
    push_frame(2, 3, 32'h60BB02, 27, -1);
    for (int i = 0; i < 4; i++) push_frame(2, 1, 32'h60, 9, 0);
    pulse_start(2);
    wait_done(2, 6000);
    chk("t6_error", int'(err_w[2]), 1);
    chk("t6_err_index", int'(eidx_w[2]), 2);
    chk("t6_done", int'(done_w[2]), 0);
    chk("t6_busy", int'(busy_w[2]), 0);
    quiet(200);
    chk("t6_max_lut_addr", max_addr2, 2);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_bus_idle", int'({scl_w[2], oe_w[2]}), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
